// File: rtl/bus_mem_slave_pkg.sv
// Shared bus definitions for the MEM-stage memory bus: widths, strobe and
// READ/WRITE encodings, and the bus slave state encoding.
package bus_mem_slave_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    BUS_SLV_IDLE = 2'd0,
    BUS_SLV_WAIT = 2'd1,
    BUS_SLV_ACK  = 2'd2
  } bus_slv_state_e;

endpackage

// File: rtl/bus_mem_slave_if.sv
// Memory bus between the MEM-stage controller (master) and a bus slave.
interface bus_mem_slave_if;
  import bus_mem_slave_pkg::*;

  logic                   cs_;
  logic                   as_;
  logic                   rw;
  logic [WORD_ADDR_W-1:0] addr;
  logic [WORD_DATA_W-1:0] wr_data;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );

endinterface

// File: rtl/bus_mem_slave_mem_array.sv
// Single-port synchronous RAM with registered read; contents are not reset
// so the array maps onto block RAM.
module bus_mem_slave_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed RAM bus slave: accepts a strobed request, inserts
// WAIT_CYCLES wait states, then acknowledges with a one-cycle rdy_ pulse.
//
// state        | meaning
// BUS_SLV_IDLE | waiting for cs_/as_; request fields sampled here only
// BUS_SLV_WAIT | counting wait states; abort if strobe drops
// BUS_SLV_ACK  | rdy_ low, read data valid / write committed on entry
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  bus_mem_slave_if.slave bus
);

  bus_slv_state_e         state, state_nx;
  logic [3:0]             cnt, cnt_nx;
  logic                   cap;
  logic [MEM_ADDR_W-1:0]  lat_addr;
  logic                   lat_rw;
  logic [WORD_DATA_W-1:0] lat_wd;

  logic                   req;
  logic                   op_rw;
  logic                   ram_we;
  logic [MEM_ADDR_W-1:0]  ram_addr;
  logic [WORD_DATA_W-1:0] ram_wd;
  logic [WORD_DATA_W-1:0] ram_rd;
  logic                   unused_addr_hi;

  assign req            = (bus.cs_ == ENABLE_) && (bus.as_ == ENABLE_);
  assign unused_addr_hi = ^bus.addr[WORD_ADDR_W-1:MEM_ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BUS_SLV_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      lat_wd   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap) begin
        lat_addr <= bus.addr[MEM_ADDR_W-1:0];
        lat_rw   <= bus.rw;
        lat_wd   <= bus.wr_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    case (state)
      BUS_SLV_IDLE: begin
        if (req) begin
          cap      = 1'b1;
          cnt_nx   = 4'(WAIT_CYCLES);
          state_nx = (WAIT_CYCLES > 0) ? BUS_SLV_WAIT : BUS_SLV_ACK;
        end
      end
      BUS_SLV_WAIT: begin
        if (!req) begin
          state_nx = BUS_SLV_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt <= 4'd1) state_nx = BUS_SLV_ACK;
        end
      end
      BUS_SLV_ACK:  state_nx = BUS_SLV_IDLE;
      default:      state_nx = BUS_SLV_IDLE;
    endcase
  end

  // With no wait states the RAM is entered straight from IDLE, so the
  // array must see the live bus fields rather than the latched copies.
  always_comb begin
    if (state == BUS_SLV_IDLE) begin
      ram_addr = bus.addr[MEM_ADDR_W-1:0];
      ram_wd   = bus.wr_data;
      op_rw    = bus.rw;
    end else begin
      ram_addr = lat_addr;
      ram_wd   = lat_wd;
      op_rw    = lat_rw;
    end
  end

  assign ram_we = (state_nx == BUS_SLV_ACK) && (op_rw == WRITE);

  bus_mem_slave_mem_array #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (WORD_DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .rd   (ram_rd)
  );

  assign bus.rdy_    = (state == BUS_SLV_ACK) ? ENABLE_ : DISABLE_;
  assign bus.rd_data = (state == BUS_SLV_ACK && lat_rw == READ) ? ram_rd : '0;

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Word-addressed on-chip RAM responder that sits on the memory bus driven by the CPU MEM-stage memory controller.
- Accepts the controller's access strobe, read/write select, 30-bit word address and 32-bit write data.
- Inserts a programmable number of wait states, then completes the access with a one-cycle active-low ready pulse and read data.
- Gives the MEM stage a real bus slave with handshake timing, replacing the zero-latency combinational memory.

Parameters:
- MEM_ADDR_W, 10: internal word-address bits; depth = 2**MEM_ADDR_W words.
- WAIT_CYCLES, 1: wait states between request acceptance and ready (0..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs_  in  1  chip select from address decoder, active low.
- as_  in  1  address strobe, active low; held by master until ready.
- rw  in  1  READ (1) / WRITE (0), codebase encoding.
- addr  in  30  word address.
- wr_data  in  32  write data.
- rd_data  out  32  read data; 0 whenever not acknowledging a read.
- rdy_  out  1  ready, active low; one-cycle pulse per completed access.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, wait counter=0, rdy_=1, rd_data=0, latched address/rw/data=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If cs_==0 and as_==0, latch addr[MEM_ADDR_W-1:0], rw and wr_data, and load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to ACK.
- WAIT:
  - Decrement the counter each cycle; go to ACK when the counter reaches 1 on the current edge.
  - If cs_ or as_ deasserts, abort to IDLE: no write, no rdy_.
- ACK (one cycle):
  - rdy_=0.
  - Read: rd_data = mem[latched addr], registered on the entry edge so it is valid for the whole ACK cycle.
  - Write: mem[latched addr] is written on the entry edge into ACK; rd_data stays 0.
  - Always return to IDLE next.
- Latency: rdy_ falls WAIT_CYCLES+1 cycles after the request edge (1 cycle when WAIT_CYCLES=0).
- Back-to-back: a request still present in the cycle after ACK is a new access, so the minimum turnaround is one IDLE cycle. The master drops or changes its strobe after sampling rdy_=0.
- Address bits above MEM_ADDR_W are ignored, so the array aliases/wraps (e.g. with MEM_ADDR_W=10, addr 0x400 maps to word 0).
- Inputs are sampled only in IDLE. Changes to addr, wr_data or rw during WAIT have no effect.
- Reset mid-WAIT or mid-ACK: immediate return to IDLE; a write whose ACK edge has not occurred is not performed.
- rd_data and rdy_ are inactive (0 and 1) outside ACK, so several slaves can be OR/AND-combined on the bus.
- No byte enables and no misalignment check; the master guarantees word alignment.

Decomposition:
- Shared headers (global_config.h / cpu.h) hold ENABLE_/DISABLE_, READ/WRITE, WORD_DATA_W=32, WORD_ADDR_W=30 and the bus slave state encodings (BUS_SLV_IDLE/WAIT/ACK, 2 bits).
- Sub-module mem_array: single-port synchronous RAM with clk, we, addr[MEM_ADDR_W], wd[32], rd[32] and registered read, inferable as block RAM.
- The FSM and wait counter live in bus_mem_slave.

Test Plan:
- Write then read, WAIT_CYCLES=1: write addr=0x5, data=0xDEADBEEF; rdy_ low exactly at cycle 2; read addr=0x5 gives rdy_ low at cycle 2 with rd_data=0xDEADBEEF, and rd_data=0 the cycle after.
- WAIT_CYCLES=0: read after writing 0x12345678 to addr 0x3FF gives rdy_ and data one cycle after the request; back-to-back reads show one idle cycle between rdy_ pulses.
- Abort: with WAIT_CYCLES=3, start a write of 0xAAAA5555 to addr 0x10 and deassert as_ in cycle 2; rdy_ never goes low and a later read of 0x10 returns the old value.
- Chip select: as_=0 with cs_=1 for 5 cycles gives rdy_=1 and rd_data=0 throughout, and no memory change.
- Alias/ignore: write 0xCAFEF00D to addr 0x400; a read of addr 0x000 returns 0xCAFEF00D. Changing addr during WAIT does not alter the accessed word.
- Reset mid-WAIT (WAIT_CYCLES=2, write 0x1 to addr 0x7): assert reset asynchronously; rdy_=1 and rd_data=0 immediately, state=IDLE, and addr 0x7 is unchanged.
